keypad_entry_buffer: RTL and testbench

//  Downstream consumer of the 4x4 keypad scanner/debouncer. Turns each debounced key code into one

---
 rtl/keypad_entry_buffer.sv | 164 ++++++++++++++++
 tb/tb_keypad_entry_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: turns debounced scanner codes into BCD edits and converts the entry to binary on enter.
// Optional build macro KEYPAD_AUTOCLR_EN blanks the buffer when each conversion completes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting key events, buffer editable
// CONV  | BCD -> binary, one digit per cycle, most significant first
// DONE  | one cycle, VALUE_VLD high, VALUE already holds the new result
module keypad_entry_buffer #(
   parameter int NUM_DIGITS  = 4,
   parameter int VAL_W       = 14,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [4:0]                KEY_IN,
   input  logic                      PRESS,
   output logic [4*NUM_DIGITS-1:0]   DIGITS,
   output logic [3:0]                DIGIT_CNT,
   output logic [VAL_W-1:0]          VALUE,
   output logic                      VALUE_VLD,
   output logic                      BUSY,
   output logic                      ERR
);

   localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [3:0]  MAX_CNT = 4'(NUM_DIGITS);
   localparam logic [3:0]  KEY_BS  = 4'hA;
   localparam logic [3:0]  KEY_CLR = 4'hB;
   localparam logic [3:0]  KEY_ENT = 4'hC;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   state_t                           state_q, state_d;
   logic [SYNC_STAGES-1:0][4:0]      key_sync;
   logic [SYNC_STAGES-1:0]           press_sync;
   logic [4:0]                       key_s;
   logic                             key_act, key_act_q, key_evt, evt_ok;
   logic [3:0]                       code;
   logic [4*NUM_DIGITS-1:0]          digits_q, digits_d, digits_ins, digits_shr;
   logic [3:0]                       cnt_q, cnt_d;
   logic                             err_q, err_d;
   logic [VAL_W-1:0]                 acc_q, acc_nxt, value_q;
   logic [IDX_W-1:0]                 idx_q;
   logic [3:0]                       cur_digit;
   logic                             busy, vld, conv_last;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         key_sync   <= '1;
         press_sync <= '0;
         key_act_q  <= 1'b0;
      end else begin
         key_sync   <= {key_sync[SYNC_STAGES-2:0], KEY_IN};
         press_sync <= {press_sync[SYNC_STAGES-2:0], PRESS};
         key_act_q  <= key_act;
      end
   end

   // Edge detector runs regardless of BUSY so a key held through a conversion never fires late.
   assign key_s   = key_sync[SYNC_STAGES-1];
   assign code    = key_s[3:0];
   assign key_act = press_sync[SYNC_STAGES-1] & ~key_s[4];
   assign key_evt = key_act & ~key_act_q;
   assign evt_ok  = key_evt && (state_q == S_IDLE);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (evt_ok && code == KEY_ENT) state_d = S_CONV;
         S_CONV:  if (idx_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      vld       = (state_q == S_DONE);
      conv_last = (state_q == S_CONV) && (idx_q == '0);
   end

   // acc*10 as (acc<<3)+(acc<<1); result is latched on the last CONV edge so VALUE is valid with VALUE_VLD.
   assign digits_shr = digits_q >> {idx_q, 2'b00};
   assign cur_digit  = digits_shr[3:0];
   assign acc_nxt    = (acc_q << 3) + (acc_q << 1) + VAL_W'(cur_digit);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         acc_q   <= '0;
         idx_q   <= '0;
         value_q <= '0;
      end else begin
         if (state_q == S_IDLE && state_d == S_CONV) begin
            acc_q <= '0;
            idx_q <= IDX_W'(NUM_DIGITS - 1);
         end else if (state_q == S_CONV) begin
            acc_q <= acc_nxt;
            idx_q <= idx_q - 1'b1;
         end
         if (conv_last) value_q <= acc_nxt;
      end
   end

   always_comb begin
      digits_d        = digits_q;
      cnt_d           = cnt_q;
      err_d           = err_q;
      digits_ins      = digits_q << 4;
      digits_ins[3:0] = code;
      if (evt_ok) begin
         if (code <= 4'd9) begin
            if (!(cnt_q == 4'd0 && code == 4'd0)) begin
               if (cnt_q < MAX_CNT) begin
                  digits_d = digits_ins;
                  cnt_d    = cnt_q + 4'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end else if (code == KEY_BS) begin
            if (cnt_q != 4'd0) begin
               digits_d = digits_q >> 4;
               cnt_d    = cnt_q - 4'd1;
            end
         end else if (code == KEY_CLR) begin
            digits_d = '0;
            cnt_d    = 4'd0;
            err_d    = 1'b0;
         end
      end
`ifdef KEYPAD_AUTOCLR_EN
      if (conv_last) begin
         digits_d = '0;
         cnt_d    = 4'd0;
      end
`endif
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         digits_q <= '0;
         cnt_q    <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         digits_q <= digits_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign DIGITS    = digits_q;
   assign DIGIT_CNT = cnt_q;
   assign VALUE     = value_q;
   assign VALUE_VLD = vld;
   assign BUSY      = busy;
   assign ERR       = err_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Randomised bench for keypad_entry_buffer; the model keeps the entry as a decimal integer plus digit count.
module tb_keypad_entry_buffer;

   localparam int N = 4;
   localparam int W = 14;
   localparam int S = 2;

   logic           CLK = 1'b0;
   logic           RESET;
   logic [4:0]     KEY_IN;
   logic           PRESS;
   logic [4*N-1:0] DIGITS;
   logic [3:0]     DIGIT_CNT;
   logic [W-1:0]   VALUE;
   logic           VALUE_VLD, BUSY, ERR;

   int n_cmp = 0;
   int n_err = 0;
   int m_num = 0, m_cnt = 0, m_err = 0, m_value = 0;
   int vld_seen = 0, vld_exp = 0;

   keypad_entry_buffer #(.NUM_DIGITS(N), .VAL_W(W), .SYNC_STAGES(S)) dut (
      .CLK(CLK), .RESET(RESET), .KEY_IN(KEY_IN), .PRESS(PRESS),
      .DIGITS(DIGITS), .DIGIT_CNT(DIGIT_CNT), .VALUE(VALUE),
      .VALUE_VLD(VALUE_VLD), .BUSY(BUSY), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (VALUE_VLD === 1'b1) vld_seen++;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] bcd_of(input int n);
      logic [31:0] r;
      int pw;
      r  = '0;
      pw = 1;
      for (int i = 0; i < N; i++) begin
         r[4*i +: 4] = 4'((n / pw) % 10);
         pw = pw * 10;
      end
      return r;
   endfunction

   // Model of one accepted edit (enter handled in do_enter).
   task automatic model_key(input int code);
      if (code <= 9) begin
         if (!(m_cnt == 0 && code == 0)) begin
            if (m_cnt < N) begin
               m_num = m_num * 10 + code;
               m_cnt++;
            end else m_err = 1;
         end
      end else if (code == 10) begin
         if (m_cnt > 0) begin
            m_num = m_num / 10;
            m_cnt--;
         end
      end else if (code == 11) begin
         m_num = 0; m_cnt = 0; m_err = 0;
      end
   endtask

   task automatic check_buf(input string tag);
      check_val({tag, ".digits"}, DIGITS, bcd_of(m_num));
      check_val({tag, ".cnt"}, DIGIT_CNT, m_cnt);
      check_val({tag, ".err"}, ERR, m_err);
   endtask

   task automatic press_key(input int code, input int hold, input int gap);
      KEY_IN = {1'b0, 4'(code)};
      PRESS  = 1'b1;
      repeat (hold) @(posedge CLK);
      #1;
      KEY_IN = 5'h1F;
      PRESS  = 1'b0;
      repeat (gap) @(posedge CLK);
      #1;
   endtask

   task automatic key(input int code, input string tag);
      press_key(code, $urandom_range(1, 4), $urandom_range(4, 7));
      model_key(code);
      check_buf(tag);
   endtask

   task automatic do_enter(input bit busy_key, input string tag);
      int vld_at, vld_n;
      vld_at = -1;
      vld_n  = 0;
      KEY_IN = 5'h0C;
      PRESS  = 1'b1;
      for (int k = 1; k <= N + 12; k++) begin
         @(posedge CLK);
         #1;
         if (k == 1) begin KEY_IN = 5'h1F; PRESS = 1'b0; end
         if (busy_key && k == 3) begin KEY_IN = 5'h08; PRESS = 1'b1; end
         if (busy_key && k == 5) begin KEY_IN = 5'h1F; PRESS = 1'b0; end
         if (VALUE_VLD === 1'b1) begin
            vld_n++;
            vld_at = k;
            check_val({tag, ".value"}, VALUE, m_num);
`ifdef KEYPAD_AUTOCLR_EN
            check_val({tag, ".autoclr_cnt"}, DIGIT_CNT, 0);
`endif
         end
         if (k == S + 1 || k == S + 1 + N) check_val({tag, ".busy"}, BUSY, 1);
         if (k == S || k == S + 2 + N) check_val({tag, ".idle"}, BUSY, 0);
      end
      check_val({tag, ".vld_at"}, vld_at, S + 1 + N);
      check_val({tag, ".vld_n"}, vld_n, 1);
      m_value = m_num;
      vld_exp++;
`ifdef KEYPAD_AUTOCLR_EN
      m_num = 0;
      m_cnt = 0;
`endif
      check_val({tag, ".value_hold"}, VALUE, m_value);
      check_buf({tag, ".after"});
   endtask

   initial begin
      RESET  = 1'b0;
      KEY_IN = 5'h1F;
      PRESS  = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check_val("rst.digits", DIGITS, 0);
      check_val("rst.cnt", DIGIT_CNT, 0);
      check_val("rst.value", VALUE, 0);
      check_val("rst.vld", VALUE_VLD, 0);
      check_val("rst.busy", BUSY, 0);
      check_val("rst.err", ERR, 0);
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // 1234 + enter
      key(1, "t1"); key(2, "t1"); key(3, "t1"); key(4, "t1");
      check_val("t1.digits", DIGITS, 16'h1234);
      do_enter(1'b0, "t1.ent");

      // leading zeros and backspace
      key(11, "t2.clr");
      key(0, "t2"); key(0, "t2"); key(7, "t2");
      check_val("t2.d7", DIGITS, 16'h0007);
      key(10, "t2.bs"); key(10, "t2.bs0");

      // overflow sets ERR, clear removes it
      key(9, "t3"); key(9, "t3"); key(9, "t3"); key(9, "t3"); key(5, "t3.full");
      check_val("t3.err", ERR, 1);
      key(11, "t3.clr");

      // long hold yields one event; D/E/F ignored
      press_key(3, 3000, 5);
      model_key(3);
      check_buf("t4.hold");
      check_val("t4.cnt", DIGIT_CNT, 1);
      key(13, "t4.d"); key(14, "t4.e"); key(15, "t4.f");

      // enter with empty buffer, key during busy ignored
      key(11, "t5.clr");
      do_enter(1'b1, "t5.ent0");
      key(1, "t5"); key(2, "t5"); key(3, "t5"); key(4, "t5");
      do_enter(1'b0, "t5.ent");

      // random traffic
      for (int i = 0; i < 150; i++) begin
         int r, c;
         r = $urandom_range(0, 99);
         if (r < 60)      c = $urandom_range(0, 9);
         else if (r < 70) c = 10;
         else if (r < 76) c = 11;
         else if (r < 84) c = 12;
         else             c = $urandom_range(13, 15);
         if (c == 12) do_enter(1'b0, "rnd.ent");
         else         key(c, "rnd");
      end

      // reset in the middle of converting 4321
      key(11, "t6.clr");
      key(4, "t6"); key(3, "t6"); key(2, "t6"); key(1, "t6");
      KEY_IN = 5'h0C;
      PRESS  = 1'b1;
      repeat (S + 2) @(posedge CLK);
      #1;
      check_val("t6.busy_pre", BUSY, 1);
      RESET = 1'b0;
      #1;
      check_val("t6.digits", DIGITS, 0);
      check_val("t6.cnt", DIGIT_CNT, 0);
      check_val("t6.value", VALUE, 0);
      check_val("t6.busy", BUSY, 0);
      check_val("t6.err", ERR, 0);
      KEY_IN = 5'h1F;
      PRESS  = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      check_val("t6.vld", VALUE_VLD, 0);
      RESET = 1'b1;
      m_num = 0; m_cnt = 0; m_err = 0; m_value = 0;
      repeat (2) @(posedge CLK);
      #1;
      key(5, "t6.post");
      check_val("t6.d5", DIGITS, 16'h0005);
      check_val("t6.value_post", VALUE, 0);

      repeat (5) @(posedge CLK);
      #1;
      check_val("vld_total", vld_seen, vld_exp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
